// File: rtl/pocket_brg_seq.sv
// pocket_brg_seq
//   Core-side sequencer for the Pocket bridge SPI link. Command words are
//   queued in a small FIFO and shifted out MSB byte first over two data lanes,
//   one bit-pair per spi_clk period. Bytes within a word are separated by a
//   programmable idle gap. spi_ss frames a transaction, which can hold several
//   words. Read words release the lanes and capture a 32-bit response.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmd_we              push strobe, one word per cycle
//   cmd_din[31:0]       command word
//   cmd_rd              word is a read slot (lanes sampled, not driven)
//   cmd_last            last word of the transaction
//   cmd_full            FIFO full
//   cmd_ovf             sticky: a push was dropped
//   busy                transaction open or FIFO not empty
//   rx_data[31:0]       captured read word
//   rx_valid            one-cycle pulse, rx_data is new
//   spi_clk             bridge clock, idles low
//   spi_ss              slave select, active low
//   spi_dout[1:0]       lane drive values {mosi,miso}
//   spi_oe              lane output enable
//   spi_din[1:0]        lane sampled values {mosi,miso}
module pocket_brg_seq #(
    parameter int CLKDIV = 24,
    parameter int GAP    = 2,
    parameter int AW     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_we,
    input  logic [31:0] cmd_din,
    input  logic        cmd_rd,
    input  logic        cmd_last,
    output logic        cmd_full,
    output logic        cmd_ovf,
    output logic        busy,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        spi_clk,
    output logic        spi_ss,
    output logic [1:0]  spi_dout,
    output logic        spi_oe,
    input  logic [1:0]  spi_din
);
    localparam int DEPTH = 1 << AW;
    localparam int DW    = $clog2(CLKDIV);
    localparam int HW    = $clog2(2 * GAP + 2);
    localparam bit HAS_GAP = (GAP > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_WAITW, S_HOLD, S_REST
    } state_t;

    state_t r_state, w_nxt;

    // Command FIFO, entries {rd, last, data}
    logic [33:0] r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [AW:0] w_count;
    logic        w_full, w_empty, w_push, w_pop;
    logic [33:0] w_head;

    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = cmd_we & ~w_full;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_rd, cmd_last, cmd_din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            cmd_ovf <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            // a push into a full FIFO is lost even if a pop frees a slot this cycle
            if (cmd_we && w_full) cmd_ovf <= 1'b1;
        end
    end

    // Half-period divider and word-progress registers
    logic [DW-1:0] r_div;
    logic          w_tick;
    logic [HW-1:0] r_hcnt;
    logic [1:0]    r_byte, r_pair;
    logic          r_rd, r_last, r_sclk;
    logic [31:0]   r_word, r_shift;
    logic [3:0]    w_nxt_idx;
    logic [1:0]    w_nxt_pair;
    logic          w_rise, w_fall, w_eow, w_gap_start, w_desel, w_park;

    assign w_tick    = (r_div == DW'(CLKDIV - 1));
    assign w_nxt_idx = {r_byte, r_pair} + 4'd1;
    // pair p of byte b sits at bit (3-b)*8 + 2p, i.e. {~b, p, 0}
    assign w_nxt_pair = r_word[{~w_nxt_idx[3:2], w_nxt_idx[1:0], 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_pop       = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_eow       = 1'b0;
        w_gap_start = 1'b0;
        w_desel     = 1'b0;
        w_park      = 1'b0;
        case (r_state)
            S_IDLE, S_WAITW: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    w_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_rise = 1'b1;
                    w_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        w_fall = 1'b1;
                        // word ends on the final falling edge; HOLD/SETUP
                        // provide the closing low half-period
                        if (r_pair == 2'd3 && r_byte == 2'd3) begin
                            w_eow = 1'b1;
                            if (r_last) begin
                                w_nxt = S_HOLD;
                            end else if (!w_empty) begin
                                w_pop = 1'b1;
                                w_nxt = S_SETUP;
                            end else begin
                                w_park = 1'b1;
                                w_nxt  = S_WAITW;
                            end
                        end
                    end else if (r_pair == 2'd0 && HAS_GAP) begin
                        // low phase after a completed byte: insert the gap
                        w_gap_start = 1'b1;
                        w_nxt       = S_GAP;
                    end else begin
                        w_rise = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick && r_hcnt == HW'(2 * GAP - 1)) begin
                    w_rise = 1'b1;
                    w_nxt  = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_desel = 1'b1;
                    w_nxt   = S_REST;
                end
            end
            S_REST: begin
                if (w_tick) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_hcnt   <= '0;
            r_byte   <= 2'd0;
            r_pair   <= 2'd0;
            r_rd     <= 1'b0;
            r_last   <= 1'b0;
            r_sclk   <= 1'b0;
            spi_ss   <= 1'b1;
            spi_oe   <= 1'b0;
            spi_dout <= 2'b00;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            // divider parks at zero while waiting so each timed state
            // starts with a full half-period
            if (r_state == S_IDLE || r_state == S_WAITW || w_tick) r_div <= '0;
            else                                                   r_div <= r_div + 1'b1;

            if (w_gap_start)                  r_hcnt <= '0;
            else if (r_state == S_GAP && w_tick) r_hcnt <= r_hcnt + 1'b1;

            if (w_pop) begin
                r_byte <= 2'd0;
                r_pair <= 2'd0;
                r_rd   <= w_head[33];
                r_last <= w_head[32];
            end else if (w_fall) begin
                {r_byte, r_pair} <= w_nxt_idx;
            end

            if (w_rise)      r_sclk <= 1'b1;
            else if (w_fall) r_sclk <= 1'b0;

            if (w_pop)        spi_ss <= 1'b0;
            else if (w_desel) spi_ss <= 1'b1;

            // lane direction only changes at word start, which is always
            // followed by a SETUP half-period before the first edge
            if (w_pop)                 spi_oe <= ~w_head[33];
            else if (w_park | w_desel) spi_oe <= 1'b0;

            if (w_pop)                         spi_dout <= w_head[33] ? 2'b00 : w_head[25:24];
            else if (w_eow | w_desel | w_park) spi_dout <= 2'b00;
            else if (w_fall && !r_rd)          spi_dout <= w_nxt_pair;

            rx_valid <= w_eow & r_rd;
            if (w_eow && r_rd) rx_data <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_word <= w_head[31:0];
        if (w_rise && r_rd) r_shift[{~r_byte, r_pair, 1'b0} +: 2] <= spi_din;
    end

    assign cmd_full = w_full;
    assign busy     = (r_state != S_IDLE) | ~w_empty;
    assign spi_clk  = r_sclk;

endmodule

// File: tb/tb_pocket_brg_seq.sv
module tb_pocket_brg_seq;
    localparam int CLKDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_din = '0;
    logic        cmd_rd = 1'b0;
    logic        cmd_last = 1'b0;
    logic        cmd_full, cmd_ovf, busy, rx_valid, spi_clk, spi_ss, spi_oe;
    logic [31:0] rx_data;
    logic [1:0]  spi_dout;
    logic [1:0]  spi_din;

    pocket_brg_seq #(.CLKDIV(CLKDIV), .GAP(2), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_we(cmd_we), .cmd_din(cmd_din), .cmd_rd(cmd_rd), .cmd_last(cmd_last),
        .cmd_full(cmd_full), .cmd_ovf(cmd_ovf), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_dout(spi_dout),
        .spi_oe(spi_oe), .spi_din(spi_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records each spi_clk rise with lane state, edge times
    int         rise_cnt = 0;
    int         rise_cyc [0:1023];
    logic [1:0] rise_dout [0:1023];
    logic       rise_oe [0:1023];
    int         last_fall = 0;
    int         ss_rise_cyc = 0;
    int         ss_fall_cnt = 0;
    int         hi_len = 0;
    int         rxv_cnt = 0;
    logic [31:0] rx_seen = '0;
    logic       prev_sclk = 1'b0;
    logic       prev_ss = 1'b1;
    int         rd_k = 0;
    logic [31:0] rd_pat = 32'hA5C3_0F96;

    // response lanes: pair k of the read word comes from byte k/4, bits 2*(k%4)
    always_comb begin
        spi_din = 2'b00;
        if (rd_k < 16) spi_din = rd_pat[((3 - rd_k / 4) * 8 + 2 * (rd_k % 4)) +: 2];
    end

    always @(negedge clk) begin
        if (spi_clk && !prev_sclk) begin
            if (rise_cnt < 1024) begin
                rise_cyc[rise_cnt]  = cyc;
                rise_dout[rise_cnt] = spi_dout;
                rise_oe[rise_cnt]   = spi_oe;
            end
            rise_cnt = rise_cnt + 1;
            if (!spi_oe) rd_k = rd_k + 1;
        end
        if (!spi_clk && prev_sclk) last_fall = cyc;
        if (spi_ss && !prev_ss) ss_rise_cyc = cyc;
        if (!spi_ss && prev_ss) begin
            ss_fall_cnt = ss_fall_cnt + 1;
            hi_len = cyc - ss_rise_cyc;
            rd_k = 0;
        end
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            rx_seen = rx_data;
        end
        prev_sclk = spi_clk;
        prev_ss   = spi_ss;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rd, input logic last, input logic [31:0] d);
        @(negedge clk);
        cmd_we = 1'b1; cmd_rd = rd; cmd_last = last; cmd_din = d;
        @(negedge clk);
        cmd_we = 1'b0; cmd_rd = 1'b0; cmd_last = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_rises(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rise_cnt >= n) break;
        end
        chk(tag, rise_cnt >= n, 1);
    endtask

    int b, f0, pc, r0;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ss", spi_ss, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_oe", spi_oe, 0);
        chk("rst_dout", spi_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full_ovf", {cmd_full, cmd_ovf, rx_valid}, 0);
        chk("rst_rxdata", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: single write 0xF8000000, last
        b = rise_cnt; f0 = ss_fall_cnt;
        push(1'b0, 1'b1, 32'hF800_0000);
        wait_idle("t1_idle", 2000);
        chk("t1_ss_falls", ss_fall_cnt - f0, 1);
        chk("t1_rises", rise_cnt - b, 16);
        chk("t1_pairs_F8", {rise_dout[b], rise_dout[b+1], rise_dout[b+2], rise_dout[b+3]}, 8'b00_10_11_11);
        chk("t1_byte2_zero", {rise_dout[b+4], rise_dout[b+8], rise_dout[b+15]}, 0);
        chk("t1_pair_period", rise_cyc[b+1] - rise_cyc[b], 2 * CLKDIV);
        chk("t1_gap_period", rise_cyc[b+4] - rise_cyc[b+3], 2 * CLKDIV + 16);
        chk("t1_gap_period3", rise_cyc[b+12] - rise_cyc[b+11], 2 * CLKDIV + 16);
        chk("t1_ss_after_fall", ss_rise_cyc - last_fall, CLKDIV);
        chk("t1_no_rxvalid", rxv_cnt, 0);

        // T2: write then read slot in one transaction
        b = rise_cnt; f0 = ss_fall_cnt;
        push(1'b0, 1'b0, 32'h1234_5678);
        push(1'b1, 1'b1, 32'h0000_0000);
        wait_idle("t2_idle", 3000);
        chk("t2_ss_falls", ss_fall_cnt - f0, 1);
        chk("t2_rises", rise_cnt - b, 32);
        chk("t2_w_pairs", {rise_dout[b], rise_dout[b+2], rise_dout[b+13], rise_dout[b+15]}, 8'b10_01_10_01);
        chk("t2_oe_write", rise_oe[b+15], 1);
        chk("t2_oe_read", rise_oe[b+16], 0);
        chk("t2_dout_read", rise_dout[b+20], 0);
        chk("t2_rx_data", rx_seen, 32'hA5C3_0F96);
        chk("t2_rxv_cnt", rxv_cnt, 1);

        // T3: overflow while the sequencer is busy shifting the lead word
        b = rise_cnt; f0 = ss_fall_cnt;
        push(1'b0, 1'b0, 32'hC0DE_0001);
        wait_rises("t3_started", b + 2, 500);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("t3_full_before_5th", cmd_full, 1);
                chk("t3_ovf_before_5th", cmd_ovf, 0);
            end
            cmd_we = 1'b1; cmd_rd = 1'b0; cmd_last = (i >= 3);
            cmd_din = 32'h1111_1111 * (i + 1);
        end
        @(negedge clk);
        cmd_we = 1'b0; cmd_last = 1'b0;
        chk("t3_ovf_after_5th", cmd_ovf, 1);
        wait_idle("t3_idle", 5000);
        chk("t3_rises", rise_cnt - b, 80);
        chk("t3_ss_falls", ss_fall_cnt - f0, 1);

        // T4: second word arrives late, WAITW holds the frame
        b = rise_cnt; f0 = ss_fall_cnt;
        push(1'b0, 1'b0, 32'h0000_00FF);
        wait_rises("t4_word1", b + 16, 1000);
        repeat (200) @(negedge clk);
        chk("t4_wait_ss", spi_ss, 0);
        chk("t4_wait_sclk", spi_clk, 0);
        chk("t4_wait_oe", spi_oe, 0);
        chk("t4_wait_busy", busy, 1);
        chk("t4_wait_rises", rise_cnt - b, 16);
        @(negedge clk);
        pc = cyc;
        cmd_we = 1'b1; cmd_last = 1'b1; cmd_din = 32'h8000_0001;
        @(negedge clk);
        cmd_we = 1'b0; cmd_last = 1'b0;
        wait_idle("t4_idle", 2000);
        chk("t4_setup_delay", rise_cyc[b+16] - pc, 2 + CLKDIV);
        chk("t4_rises", rise_cnt - b, 32);
        chk("t4_ss_falls", ss_fall_cnt - f0, 1);

        // T5: reset during the second byte
        b = rise_cnt;
        push(1'b0, 1'b1, 32'hFFFF_FFFF);
        push(1'b0, 1'b1, 32'h5555_5555);
        wait_rises("t5_byte2", b + 6, 500);
        chk("t5_pre_ovf", cmd_ovf, 1);
        chk("t5_pre_oe", spi_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ss", spi_ss, 1);
        chk("t5_rst_oe", spi_oe, 0);
        chk("t5_rst_sclk", spi_clk, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rise_cnt;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_ovf", cmd_ovf, 0);
        repeat (20) @(negedge clk);
        chk("t5_quiet", rise_cnt - r0, 0);
        chk("t5_ss_idle", spi_ss, 1);

        // T6: back-to-back single-word transactions
        b = rise_cnt; f0 = ss_fall_cnt;
        push(1'b0, 1'b1, 32'hA0A0_A0A0);
        push(1'b0, 1'b1, 32'h0505_0505);
        wait_idle("t6_idle", 3000);
        chk("t6_ss_falls", ss_fall_cnt - f0, 2);
        chk("t6_rises", rise_cnt - b, 32);
        chk("t6_desel_time", hi_len >= CLKDIV, 1);
        chk("t6_w2_pair", {rise_dout[b+16], rise_dout[b+17]}, 4'b01_01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
